// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU op encoding and ID-stage record types.
package mips_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegAw = 5;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSlt = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6,
    AluLui = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [RegAw-1:0] rs;
    logic [RegAw-1:0] rt;
    logic [RegAw-1:0] dst;
    logic [DataW-1:0] imm;
    alu_op_e          alu_op;
    logic             alu_src_imm;
    logic             reg_write;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             branch_ne;
    logic             illegal;
    logic             use_rs;
    logic             use_rt;
  } dec_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [DataW-1:0] rs_val;
    logic [DataW-1:0] rt_val;
    logic [DataW-1:0] imm;
    logic [RegAw-1:0] rs;
    logic [RegAw-1:0] rt;
    logic [RegAw-1:0] dst;
    alu_op_e          alu_op;
    logic             alu_src_imm;
    logic             reg_write;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             branch_ne;
    logic             illegal;
  } idex_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational MIPS instruction decoder: control bits, destination, immediate, source use.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic        wr;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign shamt = instr_i[10:6];
  assign imm16 = instr_i[15:0];

  always_comb begin
    dec_o        = '0;
    wr           = 1'b0;
    dec_o.rs     = instr_i[25:21];
    dec_o.rt     = instr_i[20:16];
    dec_o.dst    = instr_i[20:16];
    dec_o.imm    = {{(DataW-16){imm16[15]}}, imm16};
    dec_o.use_rs = 1'b1;
    case (op)
      OpRtype: begin
        dec_o.use_rt = 1'b1;
        dec_o.dst    = instr_i[15:11];
        dec_o.imm    = {{(DataW-5){1'b0}}, shamt};
        wr           = 1'b1;
        case (funct)
          FnAdd:   dec_o.alu_op = AluAdd;
          FnSub:   dec_o.alu_op = AluSub;
          FnAnd:   dec_o.alu_op = AluAnd;
          FnOr:    dec_o.alu_op = AluOr;
          FnSlt:   dec_o.alu_op = AluSlt;
          FnSll: begin
            dec_o.alu_op = AluSll;
            dec_o.use_rs = 1'b0;
          end
          FnSrl: begin
            dec_o.alu_op = AluSrl;
            dec_o.use_rs = 1'b0;
          end
          default: begin
            wr            = 1'b0;
            dec_o.illegal = 1'b1;
          end
        endcase
      end
      OpAddi: begin
        dec_o.alu_src_imm = 1'b1;
        wr                = 1'b1;
      end
      OpSlti: begin
        dec_o.alu_op      = AluSlt;
        dec_o.alu_src_imm = 1'b1;
        wr                = 1'b1;
      end
      OpAndi: begin
        dec_o.alu_op      = AluAnd;
        dec_o.alu_src_imm = 1'b1;
        dec_o.imm         = {{(DataW-16){1'b0}}, imm16};
        wr                = 1'b1;
      end
      OpOri: begin
        dec_o.alu_op      = AluOr;
        dec_o.alu_src_imm = 1'b1;
        dec_o.imm         = {{(DataW-16){1'b0}}, imm16};
        wr                = 1'b1;
      end
      OpLui: begin
        dec_o.alu_op      = AluLui;
        dec_o.alu_src_imm = 1'b1;
        dec_o.imm         = {imm16, {(DataW-16){1'b0}}};
        dec_o.use_rs      = 1'b0;
        wr                = 1'b1;
      end
      OpLw: begin
        dec_o.alu_src_imm = 1'b1;
        dec_o.is_load     = 1'b1;
        wr                = 1'b1;
      end
      OpSw: begin
        dec_o.alu_src_imm = 1'b1;
        dec_o.is_store    = 1'b1;
        dec_o.use_rt      = 1'b1;
      end
      OpBeq, OpBne: begin
        dec_o.alu_op    = AluSub;
        dec_o.is_branch = 1'b1;
        dec_o.branch_ne = (op == OpBne);
        dec_o.use_rt    = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded, so never request them.
    dec_o.reg_write = wr && (dec_o.dst != '0);
  end

endmodule

// File: rtl/id_stage.sv
// MIPS ID stage: operand fetch with WB bypass, load-use stall and the ID/EX register.
module id_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DataW,
  parameter int unsigned REG_AW = mips_pkg::RegAw
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc,
  output logic              id_ready,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              idex_valid,
  output logic [31:0]       idex_pc,
  output logic [DATA_W-1:0] idex_rs_val,
  output logic [DATA_W-1:0] idex_rt_val,
  output logic [DATA_W-1:0] idex_imm,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [REG_AW-1:0] idex_dst,
  output logic [3:0]        idex_alu_op,
  output logic              idex_alu_src_imm,
  output logic              idex_reg_write,
  output logic              idex_is_load,
  output logic              idex_is_store,
  output logic              idex_is_branch,
  output logic              idex_branch_ne,
  output logic              idex_illegal
);

  dec_t              dec;
  idex_t             idex_q, idex_d;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              hz, hold;

  id_decoder u_dec (
    .instr_i (if_instr),
    .dec_o   (dec)
  );

  assign rf_raddr1 = dec.rs;
  assign rf_raddr2 = dec.rt;

  // The bypass catches a WB write that lands on the same edge as our capture.
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (dec.rs == '0) rs_val = '0;
    else if (wb_we && (wb_waddr == dec.rs)) rs_val = wb_wdata;
    if (dec.rt == '0) rt_val = '0;
    else if (wb_we && (wb_waddr == dec.rt)) rt_val = wb_wdata;
  end

  assign hz = idex_q.valid && idex_q.is_load && (idex_q.dst != '0) && if_valid &&
              ((dec.use_rs && (dec.rs == idex_q.dst)) || (dec.use_rt && (dec.rt == idex_q.dst)));
  assign hold     = idex_q.valid && !ex_ready;
  assign id_ready = !hold && !hz;

  always_comb begin
    idex_d = idex_q;
    if (hold) begin
      idex_d = idex_q;
    end else if (flush || hz) begin
      idex_d.valid = 1'b0;
    end else begin
      idex_d.valid       = if_valid;
      idex_d.pc          = if_pc;
      idex_d.rs_val      = rs_val;
      idex_d.rt_val      = rt_val;
      idex_d.imm         = dec.imm;
      idex_d.rs          = dec.rs;
      idex_d.rt          = dec.rt;
      idex_d.dst         = dec.dst;
      idex_d.alu_op      = dec.alu_op;
      idex_d.alu_src_imm = dec.alu_src_imm;
      idex_d.reg_write   = dec.reg_write;
      idex_d.is_load     = dec.is_load;
      idex_d.is_store    = dec.is_store;
      idex_d.is_branch   = dec.is_branch;
      idex_d.branch_ne   = dec.branch_ne;
      idex_d.illegal     = dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign idex_valid       = idex_q.valid;
  assign idex_pc          = idex_q.pc;
  assign idex_rs_val      = idex_q.rs_val;
  assign idex_rt_val      = idex_q.rt_val;
  assign idex_imm         = idex_q.imm;
  assign idex_rs          = idex_q.rs;
  assign idex_rt          = idex_q.rt;
  assign idex_dst         = idex_q.dst;
  assign idex_alu_op      = idex_q.alu_op;
  assign idex_alu_src_imm = idex_q.alu_src_imm;
  assign idex_reg_write   = idex_q.reg_write;
  assign idex_is_load     = idex_q.is_load;
  assign idex_is_store    = idex_q.is_store;
  assign idex_is_branch   = idex_q.is_branch;
  assign idex_branch_ne   = idex_q.branch_ne;
  assign idex_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with hand-computed expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, if_valid, id_ready, wb_we, flush, ex_ready;
  logic [31:0] if_instr, if_pc, rf_rdata1, rf_rdata2, wb_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_waddr;
  logic        idex_valid;
  logic [31:0] idex_pc, idex_rs_val, idex_rt_val, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dst;
  logic [3:0]  idex_alu_op;
  logic        idex_alu_src_imm, idex_reg_write, idex_is_load, idex_is_store;
  logic        idex_is_branch, idex_branch_ne, idex_illegal;
  logic [6:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction encodings
  localparam logic [31:0] IAdd123  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] ISub411  = 32'h0021_2022; // sub $4,$1,$1
  localparam logic [31:0] ISub400  = 32'h0000_2022; // sub $4,$0,$0
  localparam logic [31:0] ILw21    = 32'h8C22_0000; // lw $2,0($1)
  localparam logic [31:0] IAdd523  = 32'h0043_2820; // add $5,$2,$3
  localparam logic [31:0] IAdd534  = 32'h0064_2820; // add $5,$3,$4
  localparam logic [31:0] IAddiM1  = 32'h2001_FFFF; // addi $1,$0,-1
  localparam logic [31:0] IOriFfff = 32'h3401_FFFF; // ori $1,$0,0xffff
  localparam logic [31:0] ILui     = 32'h3C01_1234; // lui $1,0x1234
  localparam logic [31:0] IBad     = 32'hFC00_0000; // opcode 0x3f

  id_stage dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .id_ready         (id_ready),
    .rf_raddr1        (rf_raddr1),
    .rf_raddr2        (rf_raddr2),
    .rf_rdata1        (rf_rdata1),
    .rf_rdata2        (rf_rdata2),
    .wb_we            (wb_we),
    .wb_waddr         (wb_waddr),
    .wb_wdata         (wb_wdata),
    .flush            (flush),
    .ex_ready         (ex_ready),
    .idex_valid       (idex_valid),
    .idex_pc          (idex_pc),
    .idex_rs_val      (idex_rs_val),
    .idex_rt_val      (idex_rt_val),
    .idex_imm         (idex_imm),
    .idex_rs          (idex_rs),
    .idex_rt          (idex_rt),
    .idex_dst         (idex_dst),
    .idex_alu_op      (idex_alu_op),
    .idex_alu_src_imm (idex_alu_src_imm),
    .idex_reg_write   (idex_reg_write),
    .idex_is_load     (idex_is_load),
    .idex_is_store    (idex_is_store),
    .idex_is_branch   (idex_is_branch),
    .idex_branch_ne   (idex_branch_ne),
    .idex_illegal     (idex_illegal)
  );

  always #5 clk = ~clk;

  assign flags = {idex_alu_src_imm, idex_reg_write, idex_is_load, idex_is_store,
                  idex_is_branch, idex_branch_ne, idex_illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'b0, idex_valid}, 32'h0);
    chk({tag, ".pc"}, idex_pc, 32'h0);
    chk({tag, ".rs_val"}, idex_rs_val, 32'h0);
    chk({tag, ".rt_val"}, idex_rt_val, 32'h0);
    chk({tag, ".imm"}, idex_imm, 32'h0);
    chk({tag, ".regs"}, {17'b0, idex_rs, idex_rt, idex_dst}, 32'h0);
    chk({tag, ".alu_op"}, {28'b0, idex_alu_op}, 32'h0);
    chk({tag, ".flags"}, {25'b0, flags}, 32'h0);
    chk({tag, ".id_ready"}, {31'b0, id_ready}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    flush = 1'b0; ex_ready = 1'b1;
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // R-type decode
    rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
    present(IAdd123, 32'h100);
    chk("add.raddr", {22'b0, rf_raddr1, rf_raddr2}, {22'b0, 5'd1, 5'd2});
    tick();
    chk("add.valid", {31'b0, idex_valid}, 32'h1);
    chk("add.rs_val", idex_rs_val, 32'd5);
    chk("add.rt_val", idex_rt_val, 32'd7);
    chk("add.regs", {17'b0, idex_rs, idex_rt, idex_dst}, {17'b0, 5'd1, 5'd2, 5'd3});
    chk("add.alu_op", {28'b0, idex_alu_op}, 32'd0);
    chk("add.flags", {25'b0, flags}, 32'b010_0000);
    chk("add.pc", idex_pc, 32'h100);

    // WB bypass
    rf_rdata1 = 32'h11; rf_rdata2 = 32'h11;
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hAA;
    present(ISub411, 32'h104);
    tick();
    chk("byp.rs_val", idex_rs_val, 32'hAA);
    chk("byp.rt_val", idex_rt_val, 32'hAA);
    chk("byp.alu_op", {28'b0, idex_alu_op}, 32'd1);
    chk("byp.dst", {27'b0, idex_dst}, 32'd4);
    wb_waddr = 5'd0;
    present(ISub400, 32'h108);
    tick();
    chk("byp0.rs_val", idex_rs_val, 32'h0);
    chk("byp0.rt_val", idex_rt_val, 32'h0);
    present(ISub411, 32'h10C);
    tick();
    chk("bypmiss.rs_val", idex_rs_val, 32'h11);
    wb_we = 1'b0;

    // Load-use stall
    rf_rdata1 = 32'h1000;
    present(ILw21, 32'h200);
    tick();
    chk("lw.flags", {25'b0, flags}, 32'b111_0000);
    chk("lw.dst", {27'b0, idex_dst}, 32'd2);
    rf_rdata1 = 32'h33; rf_rdata2 = 32'h44;
    present(IAdd523, 32'h204);
    chk("lu.ready0", {31'b0, id_ready}, 32'h0);
    tick();
    chk("lu.bubble", {31'b0, idex_valid}, 32'h0);
    chk("lu.ready1", {31'b0, id_ready}, 32'h1);
    tick();
    chk("lu.valid", {31'b0, idex_valid}, 32'h1);
    chk("lu.pc", idex_pc, 32'h204);
    chk("lu.rs_val", idex_rs_val, 32'h33);
    present(ILw21, 32'h208);
    tick();
    present(IAdd534, 32'h20C);
    chk("nolu.ready", {31'b0, id_ready}, 32'h1);
    tick();
    chk("nolu.valid", {31'b0, idex_valid}, 32'h1);
    chk("nolu.pc", idex_pc, 32'h20C);

    // Immediates and illegal
    present(IAddiM1, 32'h210);
    tick();
    chk("addi.imm", idex_imm, 32'hFFFF_FFFF);
    chk("addi.flags", {25'b0, flags}, 32'b110_0000);
    present(IOriFfff, 32'h214);
    tick();
    chk("ori.imm", idex_imm, 32'h0000_FFFF);
    present(ILui, 32'h218);
    tick();
    chk("lui.imm", idex_imm, 32'h1234_0000);
    chk("lui.alu_op", {28'b0, idex_alu_op}, 32'd7);
    present(IBad, 32'h21C);
    tick();
    chk("bad.valid", {31'b0, idex_valid}, 32'h1);
    chk("bad.flags", {25'b0, flags}, 32'b000_0001);

    // Hold and flush
    present(IAdd123, 32'h300);
    tick();
    ex_ready = 1'b0;
    present(ISub411, 32'h304);
    for (int i = 0; i < 3; i++) begin
      chk("hold.ready", {31'b0, id_ready}, 32'h0);
      tick();
      chk("hold.pc", idex_pc, 32'h300);
      chk("hold.valid", {31'b0, idex_valid}, 32'h1);
    end
    flush = 1'b1;
    tick();
    chk("flushhold.pc", idex_pc, 32'h300);
    chk("flushhold.valid", {31'b0, idex_valid}, 32'h1);
    ex_ready = 1'b1;
    tick();
    chk("flush.valid", {31'b0, idex_valid}, 32'h0);
    flush = 1'b0;

    // Reset in the middle of a load-use stall
    present(ILw21, 32'h400);
    tick();
    present(IAdd523, 32'h404);
    chk("rststall.ready", {31'b0, id_ready}, 32'h0);
    reset = 1'b1;
    tick();
    chk_all_zero("rststall");
    reset = 1'b0;
    tick();
    chk("postrst.pc", idex_pc, 32'h404);
    chk("postrst.valid", {31'b0, idex_valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
